// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store data port: decoder load/store codes and FSM states.
package lsu_pkg;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b011;
    localparam logic [2:0] LHU = 3'b100;

    localparam logic [1:0] SB = 2'b00;
    localparam logic [1:0] SH = 2'b01;
    localparam logic [1:0] SW = 2'b10;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DONE
    } lsu_state_t;

endpackage

// File: rtl/lsu_data_port_if.sv
// Word-wide data-memory bus with req/ack handshake.
interface lsu_data_port_if;

    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_wstrb;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    modport master (
        output bus_req, bus_we, bus_addr, bus_wstrb, bus_wdata,
        input  bus_ack, bus_rdata
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_wstrb, bus_wdata,
        output bus_ack, bus_rdata
    );

endinterface

// File: rtl/lsu_align.sv
// Combinational byte-lane logic: store steering/strobes, misalign detect, load extraction/extension.
module lsu_align
    import lsu_pkg::*;
(
    input  logic        is_write,
    input  logic [1:0]  store,
    input  logic [2:0]  load,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [2:0]  ld_load,
    input  logic [1:0]  ld_off,
    input  logic [31:0] rdata,
    output logic [31:0] wdata_lane,
    output logic [3:0]  wstrb,
    output logic        misalign,
    output logic [31:0] rdata_fmt
);

    logic [31:0] shifted;

    always_comb begin
        wdata_lane = wdata;
        wstrb      = 4'b1111;
        case (store)
            SB: begin
                wdata_lane = {4{wdata[7:0]}};
                wstrb      = 4'b0001 << addr_lo;
            end
            SH: begin
                wdata_lane = {2{wdata[15:0]}};
                wstrb      = addr_lo[1] ? 4'b1100 : 4'b0011;
            end
            default: ;
        endcase
    end

    // Store code wins when both enables are high; 11 and 101-111 fall into word handling.
    always_comb begin
        misalign = 1'b0;
        if (is_write) begin
            case (store)
                SB:      misalign = 1'b0;
                SH:      misalign = addr_lo[0];
                default: misalign = |addr_lo;
            endcase
        end else begin
            case (load)
                LB, LBU: misalign = 1'b0;
                LH, LHU: misalign = addr_lo[0];
                default: misalign = |addr_lo;
            endcase
        end
    end

    always_comb begin
        shifted = rdata >> {ld_off, 3'b000};
        case (ld_load)
            LB:      rdata_fmt = {{24{shifted[7]}}, shifted[7:0]};
            LH:      rdata_fmt = {{16{shifted[15]}}, shifted[15:0]};
            LBU:     rdata_fmt = {24'h000000, shifted[7:0]};
            LHU:     rdata_fmt = {16'h0000, shifted[15:0]};
            LW:      rdata_fmt = shifted;
            default: rdata_fmt = shifted;
        endcase
    end

endmodule

// File: rtl/lsu_data_port.sv
// Load/store data port: IDLE/REQ/DONE FSM, access latches and bus timeout counter.
module lsu_data_port
    import lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_write,
    input  logic        mem_read,
    input  logic [1:0]  store,
    input  logic [2:0]  load,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        stall,
    output logic [31:0] load_data,
    output logic        misalign,
    output logic        bus_err,
    lsu_data_port_if.master bus
);

    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    lsu_state_t  state;
    logic [CW-1:0] cnt;
    logic        lat_write;
    logic [2:0]  lat_load;
    logic [1:0]  lat_off;

    logic        access;
    logic [31:0] wdata_lane;
    logic [3:0]  wstrb;
    logic        mis;
    logic [31:0] rdata_fmt;

    lsu_align u_align (
        .is_write   (mem_write),
        .store      (store),
        .load       (load),
        .addr_lo    (addr[1:0]),
        .wdata      (wdata),
        .ld_load    (lat_load),
        .ld_off     (lat_off),
        .rdata      (bus.bus_rdata),
        .wdata_lane (wdata_lane),
        .wstrb      (wstrb),
        .misalign   (mis),
        .rdata_fmt  (rdata_fmt)
    );

    always_comb begin
        access = mem_read | mem_write;
        stall  = ((state == IDLE) && access) || (state == REQ);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            cnt           <= '0;
            lat_write     <= 1'b0;
            lat_load      <= '0;
            lat_off       <= '0;
            load_data     <= '0;
            misalign      <= 1'b0;
            bus_err       <= 1'b0;
            bus.bus_req   <= 1'b0;
            bus.bus_we    <= 1'b0;
            bus.bus_addr  <= '0;
            bus.bus_wstrb <= '0;
            bus.bus_wdata <= '0;
        end else begin
            misalign <= 1'b0;
            bus_err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (access) begin
                        lat_write <= mem_write;
                        lat_load  <= load;
                        lat_off   <= addr[1:0];
                        load_data <= '0;
                        cnt       <= '0;
                        if (mis) begin
                            misalign <= 1'b1;
                            state    <= DONE;
                        end else begin
                            bus.bus_req   <= 1'b1;
                            bus.bus_we    <= mem_write;
                            bus.bus_addr  <= {addr[31:2], 2'b00};
                            bus.bus_wstrb <= mem_write ? wstrb : 4'b0000;
                            bus.bus_wdata <= wdata_lane;
                            state         <= REQ;
                        end
                    end
                end
                REQ: begin
                    // An ack in the final allowed cycle still completes the access normally.
                    if (bus.bus_ack || (cnt == CW'(TIMEOUT - 1))) begin
                        bus.bus_req   <= 1'b0;
                        bus.bus_we    <= 1'b0;
                        bus.bus_wstrb <= '0;
                        state         <= DONE;
                        if (bus.bus_ack) begin
                            load_data <= lat_write ? '0 : rdata_fmt;
                        end else begin
                            load_data <= '0;
                            bus_err   <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/lsu_data_port.md
# lsu_data_port

Load/store data port sitting directly downstream of the main decoder: it consumes the decoder's MemWrite, ResultSrc-derived read enable, Store and Load codes, plus the ALU-computed address and rs2 data. It drives a word-wide data-memory bus with a req/ack handshake. It stalls the core until the access completes, then returns the aligned and extended load data to the result mux. Byte-lane steering, misalignment detection and bus timeout are handled here.

## Interface
- `TIMEOUT`, default 255: maximum number of cycles in REQ waiting for `bus_ack`.
- `clk` in 1: core clock.
- `rst_n` in 1: reset, synchronous, active-low.
- `mem_write` in 1: decoder MemWrite.
- `mem_read` in 1: high when ResultSrc == 2'b01, i.e. a load.
- `store` in 2: 00 sb, 01 sh, 10 sw; 11 is treated as sw.
- `load` in 3: 000 lb, 001 lh, 010 lw, 011 lbu, 100 lhu; 101–111 are treated as lw.
- `addr` in 32: ALU result, the byte address.
- `wdata` in 32: rs2 value.
- `stall` out 1: freezes PC and the pipeline register while high.
- `load_data` out 32: formatted load result; valid in DONE.
- `misalign` out 1: one-cycle pulse; the access is dropped.
- `bus_err` out 1: one-cycle pulse on timeout.
- `bus_req` out 1: bus request.
- `bus_we` out 1: bus write enable.
- `bus_addr` out 32: word address, `{addr[31:2], 2'b00}`.
- `bus_wstrb` out 4: byte write strobes.
- `bus_wdata` out 32: lane-steered write data.
- `bus_ack` in 1: bus completion.
- `bus_rdata` in 32: bus read word.

## Operation
- FSM states: IDLE, REQ, DONE.
- **IDLE**
  - An access is present when `mem_read | mem_write`. If both are high, the write takes priority.
  - On an access: latch the type, `addr[1:0]`, steered write data and strobes.
  - Aligned access: go to REQ.
  - Misaligned access (lh/lhu/sh with `addr[0]`; lw/sw with `addr[1:0] != 0`): go to DONE with the misalign flag set.
- **REQ**
  - `bus_req` = 1. `bus_we`, `bus_addr`, `bus_wstrb` and `bus_wdata` come from registers and stay stable until ack.
  - On `bus_ack`: register the formatted `bus_rdata` into `load_data` (0 for stores) and go to DONE.
  - The timeout counter increments each REQ cycle. When it reaches TIMEOUT without ack, go to DONE with the error flag set and `load_data` = 0.
- **DONE**
  - `stall` = 0 so the instruction retires.
  - `misalign` and `bus_err` pulse here if flagged.
  - Always returns to IDLE. The still-asserted `mem_read`/`mem_write` of the retiring instruction is ignored in this cycle.
- `stall` = (IDLE & access present) | REQ. It is combinational from the inputs in IDLE.
- Store steering:
  - sb: `{4{wdata[7:0]}}`, strobe `4'b0001 << addr[1:0]`.
  - sh: `{2{wdata[15:0]}}`, strobe 0011 when `addr[1]` = 0, else 1100.
  - sw: `wdata`, strobe 1111.
- Load extraction:
  - Shift: `bus_rdata >> (8*addr[1:0])`.
  - lb/lh: sign-extend from bit 7 or bit 15.
  - lbu/lhu: zero-extend.
  - lw: the full word.
- `bus_ack` outside REQ is ignored.

## Timing
- Reset values: state IDLE, `bus_req` 0, `bus_we` 0, `bus_wstrb` 0, `bus_addr` 0, `bus_wdata` 0, `load_data` 0, `misalign` 0, `bus_err` 0, counter 0.
- `stall` reflects the inputs in IDLE.
- Best case, ack on the first REQ cycle: detect cycle, REQ cycle, DONE cycle, i.e. 3 cycles per memory instruction (2 stalled).
- Each extra wait cycle on the bus adds one cycle.
- Misaligned access: 2 cycles, and `bus_req` never rises.
- Timeout: `bus_req` is high for exactly TIMEOUT cycles; `bus_err` pulses in the following cycle (DONE).
- Reset mid-REQ: `bus_req` drops at that edge and the FSM returns to IDLE. A late `bus_ack` is ignored.
- Back-to-back memory instructions: the next access is detected in the IDLE cycle after DONE.

## Structure
- Package `lsu_pkg` holds:
  - the load codes (LB, LH, LW, LBU, LHU) and store codes (SB, SH, SW), matching the main decoder encodings;
  - the state enum `{IDLE, REQ, DONE}`.
- Sub-module `lsu_align` is purely combinational: store steering and strobes, load extraction and extension, misalign detect.
- Top level holds the FSM, the latches and the timeout counter.

## Test plan
- sb, addr 0x1003, wdata 0xAB, ack on first REQ cycle -> `bus_addr` 0x1000, `bus_wstrb` 1000, `bus_wdata` 0xABABABAB, `stall` high 2 cycles.
- lb, addr 0x2001, `bus_rdata` 0x0000_8000 -> `load_data` 0xFFFFFF80. lbu at the same address -> 0x00000080.
- lhu, addr 0x2002, `bus_rdata` 0xBEEF_1234 -> `load_data` 0x0000BEEF. lh at the same address -> 0xFFFFBEEF.
- lw, addr 0x3002 -> `misalign` pulses in cycle 2, `bus_req` never asserted, `load_data` 0.
- sw with ack withheld, TIMEOUT = 4 -> `bus_req` high exactly 4 cycles, then `bus_err` pulse, then IDLE.
- lw with `rst_n` low in the 2nd REQ cycle -> all outputs reset at that edge. An ack in the next cycle is ignored and state stays IDLE.
